// File: rtl/bn_sign_out.sv
// Binarizes each MVM result element against its batch-norm threshold and streams the packed bits out in OUT_W-bit words.
// Optional macro BN_SIGN_OUT_CNT_EN adds a completed-vector counter and a saturating drop counter.
module bn_sign_out #(
    parameter int NUM_BIT = 8,
    parameter int DIM     = 8,
    parameter int OUT_W   = 4
) (
    input  logic               i_clk_bnOut,
    input  logic               i_rst_n_bnOut,
    input  logic [NUM_BIT-1:0] i_y_vector [DIM-1:0],
    input  logic               i_isAcc,
    input  logic [NUM_BIT-1:0] i_thresh   [DIM-1:0],
    output logic [OUT_W-1:0]   o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_last,
    output logic               o_busy,
    output logic               o_overrun
`ifdef BN_SIGN_OUT_CNT_EN
    ,
    output logic [15:0]        o_vec_cnt,
    output logic [7:0]         o_drop_cnt
`endif
);

    localparam int NWORDS = DIM / OUT_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OUT  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DIM-1:0]   bits_q, bits_d;
    logic             overrun_q, overrun_d;
    logic             isAcc_q;

    logic [DIM-1:0]   cmpBits;
    logic             capture;
    logic             handshake;
    logic             lastHs;
    logic             dropEvt;
    logic [OUT_W-1:0] words [NWORDS];

    // Signed compare on the raw operands, so extreme values cannot overflow.
    always_comb begin
        cmpBits = '0;
        for (int i = 0; i < DIM; i++) begin
            cmpBits[i] = ($signed(i_y_vector[i]) >= $signed(i_thresh[i]));
        end
    end

    assign capture   = isAcc_q & ~i_isAcc;
    assign handshake = (state_q == ST_OUT) & i_ready;
    assign lastHs    = handshake & (idx_q == LAST_IDX);
    assign dropEvt   = capture & (state_q == ST_OUT) & ~lastHs;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bits_d    = bits_q;
        overrun_d = overrun_q | dropEvt;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    bits_d  = cmpBits;
                    idx_d   = '0;
                    state_d = ST_OUT;
                end
            end
            default: begin
                if (lastHs) begin
                    idx_d = '0;
                    // A capture landing on the final handshake chains straight into the next vector.
                    if (capture) begin
                        bits_d = cmpBits;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (handshake) begin
                    idx_d = idx_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk_bnOut or negedge i_rst_n_bnOut) begin
        if (!i_rst_n_bnOut) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            bits_q    <= '0;
            overrun_q <= 1'b0;
            isAcc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            bits_q    <= bits_d;
            overrun_q <= overrun_d;
            isAcc_q   <= i_isAcc;
        end
    end

    for (genvar w = 0; w < NWORDS; w++) begin : g_words
        assign words[w] = bits_q[w*OUT_W +: OUT_W];
    end

    assign o_data    = words[idx_q];
    assign o_valid   = (state_q == ST_OUT);
    assign o_busy    = (state_q == ST_OUT);
    assign o_last    = (state_q == ST_OUT) && (idx_q == LAST_IDX);
    assign o_overrun = overrun_q;

`ifdef BN_SIGN_OUT_CNT_EN
    logic [15:0] vecCnt_q;
    logic [7:0]  dropCnt_q;

    always_ff @(posedge i_clk_bnOut or negedge i_rst_n_bnOut) begin
        if (!i_rst_n_bnOut) begin
            vecCnt_q  <= '0;
            dropCnt_q <= '0;
        end else begin
            if (lastHs) begin
                vecCnt_q <= vecCnt_q + 16'd1;
            end
            if (dropEvt && (dropCnt_q != 8'hFF)) begin
                dropCnt_q <= dropCnt_q + 8'd1;
            end
        end
    end

    assign o_vec_cnt  = vecCnt_q;
    assign o_drop_cnt = dropCnt_q;
`endif

endmodule
